// File: rtl/wb_port_pkg.sv
// Shared constants, FSM state type and decode helper for the wb_port responder.
package wb_port_pkg;

    localparam logic [5:0]  OFF_CHECK     = 6'd8;
    localparam logic [5:0]  OFF_CHECK_OEB = 6'd9;
    localparam logic [5:0]  OFF_TXN_CNT   = 6'd10;
    localparam logic [5:0]  OFF_ID        = 6'd11;
    localparam logic [31:0] ID_VALUE      = 32'h5750_5254;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Scratch words sit below the fixed registers; anything else is an error.
    function automatic logic off_valid(input logic [5:0] off, input int nreg);
        return (off < 6'(nreg)) || ((off >= OFF_CHECK) && (off <= OFF_ID));
    endfunction

endpackage

// File: rtl/wb_port_regs.sv
// Register bank: byte-masked scratch words, CHECK/CHECK_OEB pads, transaction counter.
module wb_port_regs
    import wb_port_pkg::*;
#(
    parameter int NREG = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [5:0]  off,
    input  logic [3:0]  sel,
    input  logic [31:0] wdata,
    input  logic        inc,
    output logic [31:0] rdata,
    output logic [15:0] check,
    output logic [15:0] check_oeb
);

    logic [31:0] scratch_w [NREG];
    logic [15:0] check_reg;
    logic [15:0] check_oeb_reg;
    logic [31:0] txn_cnt_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_scratch
            logic [31:0] word_reg;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    word_reg <= '0;
                end else if (wr_en && (off == 6'(gi))) begin
                    for (int b = 0; b < 4; b++) begin
                        if (sel[b]) word_reg[8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end
            assign scratch_w[gi] = word_reg;
        end
    endgenerate

    // Only the low half is stored; the upper byte lanes of the write are dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            check_reg     <= '0;
            check_oeb_reg <= 16'hFFFF;
            txn_cnt_reg   <= '0;
        end else begin
            if (wr_en && (off == OFF_CHECK)) begin
                if (sel[0]) check_reg[7:0]  <= wdata[7:0];
                if (sel[1]) check_reg[15:8] <= wdata[15:8];
            end
            if (wr_en && (off == OFF_CHECK_OEB)) begin
                if (sel[0]) check_oeb_reg[7:0]  <= wdata[7:0];
                if (sel[1]) check_oeb_reg[15:8] <= wdata[15:8];
            end
            if (inc) txn_cnt_reg <= txn_cnt_reg + 32'd1;
        end
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < NREG; i++) begin
            if (off == 6'(i)) rdata = scratch_w[i];
        end
        case (off)
            OFF_CHECK:     rdata = {16'h0000, check_reg};
            OFF_CHECK_OEB: rdata = {16'h0000, check_oeb_reg};
            OFF_TXN_CNT:   rdata = txn_cnt_reg;
            OFF_ID:        rdata = ID_VALUE;
            default:       ;
        endcase
    end

    assign check     = check_reg;
    assign check_oeb = check_oeb_reg;

endmodule

// File: rtl/wb_port_resp.sv
// Wishbone classic responder with programmable wait states ahead of each ack/err.
module wb_port_resp
    import wb_port_pkg::*;
#(
    parameter int          NREG      = 8,
    parameter int          WAIT_CYC  = 2,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        wbs_err_o,
    output logic [15:0] check_o,
    output logic [15:0] check_oeb_o
);

    state_t      state_reg, state_next;
    logic [3:0]  wait_reg, wait_next;
    logic        cap_we_reg;
    logic [3:0]  cap_sel_reg;
    logic [5:0]  cap_off_reg;
    logic        cap_hit_reg;
    logic [31:0] cap_dat_reg;

    logic        req;
    logic        live_hit;
    logic        cur_we;
    logic [3:0]  cur_sel;
    logic [5:0]  cur_off;
    logic        cur_hit;
    logic [31:0] cur_dat;
    logic        go_resp;
    logic        dec_ok;
    logic [31:0] rd_data;
    logic        adr_lsb_unused;

    assign req            = wbs_cyc_i & wbs_stb_i;
    assign live_hit       = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign adr_lsb_unused = ^wbs_adr_i[1:0];

    // With zero wait states the response is produced straight from the live bus.
    always_comb begin
        if (state_reg == IDLE) begin
            cur_we  = wbs_we_i;
            cur_sel = wbs_sel_i;
            cur_off = wbs_adr_i[7:2];
            cur_hit = live_hit;
            cur_dat = wbs_dat_i;
        end else begin
            cur_we  = cap_we_reg;
            cur_sel = cap_sel_reg;
            cur_off = cap_off_reg;
            cur_hit = cap_hit_reg;
            cur_dat = cap_dat_reg;
        end
    end

    always_comb begin
        state_next = state_reg;
        wait_next  = wait_reg;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    wait_next  = 4'(WAIT_CYC);
                    state_next = (WAIT_CYC == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (!wbs_cyc_i) begin
                    state_next = IDLE;
                end else begin
                    wait_next = wait_reg - 4'd1;
                    if (wait_reg <= 4'd1) state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign go_resp = (state_next == RESP);
    assign dec_ok  = cur_hit && off_valid(cur_off, NREG);

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            state_reg   <= IDLE;
            wait_reg    <= '0;
            cap_we_reg  <= 1'b0;
            cap_sel_reg <= '0;
            cap_off_reg <= '0;
            cap_hit_reg <= 1'b0;
            cap_dat_reg <= '0;
            wbs_ack_o   <= 1'b0;
            wbs_err_o   <= 1'b0;
            wbs_dat_o   <= '0;
        end else begin
            state_reg <= state_next;
            wait_reg  <= wait_next;
            if ((state_reg == IDLE) && req) begin
                cap_we_reg  <= wbs_we_i;
                cap_sel_reg <= wbs_sel_i;
                cap_off_reg <= wbs_adr_i[7:2];
                cap_hit_reg <= live_hit;
                cap_dat_reg <= wbs_dat_i;
            end
            // rd_data is sampled on the commit edge, so it is the pre-write value.
            wbs_ack_o <= go_resp && dec_ok;
            wbs_err_o <= go_resp && !dec_ok;
            wbs_dat_o <= (go_resp && dec_ok) ? rd_data : 32'h0;
        end
    end

    wb_port_regs #(
        .NREG(NREG)
    ) u_regs (
        .clk       (wb_clk_i),
        .rst_n     (wb_rst_n),
        .wr_en     (go_resp && dec_ok && cur_we),
        .off       (cur_off),
        .sel       (cur_sel),
        .wdata     (cur_dat),
        .inc       (go_resp && dec_ok),
        .rdata     (rd_data),
        .check     (check_o),
        .check_oeb (check_oeb_o)
    );

endmodule

// File: doc/wb_port_resp.md
Name: wb_port_resp

Overview:
- Wishbone classic responder inside the user project. It answers the management SoC's wbs_* master port.
- Provides a byte-writable scratch register bank, a transaction counter, and a check register. The check register drives the 16 checkbits that the chip-level monitor watches on mprj_io[31:16].
- Inserts a programmable number of wait states before each ack, so the master's stall handling gets exercised.

Parameters:
- NREG, 8, number of 32-bit scratch registers at offsets 0x00..(NREG-1)*4; legal range 1..8.
- WAIT_CYC, 2, wait states from request capture to ack; legal range 0..15.
- BASE_ADDR, 32'h3000_0000, region base; only bits [31:8] are compared.

Ports:
- wb_clk_i  in  1  single clock for the whole block.
- wb_rst_n  in  1  reset, synchronous, active-low.
- wbs_cyc_i  in  1  bus cycle valid.
- wbs_stb_i  in  1  strobe.
- wbs_we_i  in  1  1 = write, 0 = read.
- wbs_sel_i  in  4  byte enables.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_dat_o  out  32  read data; valid only while wbs_ack_o = 1.
- wbs_ack_o  out  1  one-cycle normal termination.
- wbs_err_o  out  1  one-cycle error termination.
- check_o  out  16  checkbits, CHECK register [15:0].
- check_oeb_o  out  16  output enable bar for the checkbit pads, CHECK_OEB register [15:0].

Behaviour:
- Reset values, applied on a wb_clk_i edge while wb_rst_n = 0:
  - wbs_ack_o = 0, wbs_err_o = 0, wbs_dat_o = 0.
  - All scratch registers = 0, CHECK = 0, TXN_CNT = 0.
  - CHECK_OEB = 16'hFFFF (pads tristated).
  - FSM returns to IDLE.
  - Reset asserted mid-transaction aborts it: no write is committed and no ack or err is issued.
- Request: req = wbs_cyc_i & wbs_stb_i. A request is accepted only in IDLE.
- Address decode:
  - hit = (wbs_adr_i[31:8] == BASE_ADDR[31:8]); off = wbs_adr_i[7:2].
  - off 0..NREG-1: SCRATCH[off], read/write, byte-masked by wbs_sel_i.
  - off 8 (0x20): CHECK, read/write; only bits [15:0] are stored, bits [31:16] read as 0.
  - off 9 (0x24): CHECK_OEB, read/write, same width rule as CHECK.
  - off 10 (0x28): TXN_CNT, 32-bit, read-only. A write is acked and discarded.
  - off 11 (0x2C): ID, constant 32'h5750_5254. A write is acked and discarded.
  - Anything else, or hit = 0: error.
  - wbs_adr_i[1:0] is ignored.
- FSM states:
  - IDLE: on req, capture we, sel, adr, dat and load wait counter = WAIT_CYC. Go to WAIT, or straight to RESP if WAIT_CYC = 0.
  - WAIT: decrement the counter each cycle; go to RESP when it reaches 0. If wbs_cyc_i falls, abort to IDLE with no side effects.
  - RESP: for one cycle, drive ack = 1 (or err = 1 if decode failed).
    - The write commits on the same edge that raises ack.
    - wbs_dat_o carries the read data, which is the register value before any same-cycle write.
    - Next state is IDLE.
- Latency: ack is high WAIT_CYC+1 cycles after the cycle in which req is first sampled high in IDLE. Back-to-back requests are separated by at least one IDLE cycle.
- ack and err are never high together and each lasts exactly one cycle. wbs_dat_o returns to 0 when ack is low.
- TXN_CNT increments by 1 on each ack, for reads and writes, and wraps from 32'hFFFF_FFFF to 0. It does not increment on err or on an aborted cycle.
- wbs_sel_i = 0 on a write: acked, no register changes.
- Inputs that change during WAIT are ignored; the captured values are used.

Decomposition:
- Shared package wb_port_pkg holds:
  - offset constants OFF_CHECK, OFF_CHECK_OEB, OFF_TXN_CNT, OFF_ID;
  - ID_VALUE;
  - the FSM state enum {IDLE, WAIT, RESP}.
- One sub-module, wb_port_regs: the register bank (byte-masked write, read mux, CHECK/CHECK_OEB, TXN_CNT). The top level keeps the FSM, decode and wait counter.

Test Plan:
- Reset then read 0x3000_0024 -> ack after 3 cycles, data 32'h0000_FFFF; check_o = 0.
- Write 0x3000_0020 = 32'h1234_AB60, sel = 4'hF -> check_o = 16'hAB60 on the ack edge. Write 0x0000_AB6A -> check_o = 16'hAB6A. Read back -> 32'h0000_AB6A.
- Write SCRATCH[3] = 32'hFFFF_FFFF, then write 32'h0000_0000 with sel = 4'b0101 -> read gives 32'hFF00_FF00.
- Read 0x3000_0040 and 0x3100_0000 -> err for one cycle, no ack. TXN_CNT is unchanged.
- Drop wbs_cyc_i during WAIT on a write to SCRATCH[0] -> no ack, SCRATCH[0] keeps its old value. The next request completes normally.
- Perform 5 acked transactions, then read TXN_CNT -> 5; this read is itself counted, so a second read returns 6. Force TXN_CNT to 32'hFFFF_FFFF, then one ack -> 0.
